scene_sequencer: RTL

Parametrised top-level render controller that replaces the single-scene master FSM. It sequences the vertex loader, optionally clears the frame buffer, then feeds a run-time-selectable number of triangles to the filled-triangle rasteriser. It then releases the VGA timing block for display. In continuous mode it re-clears and re-draws on every frame tick without reloading.

---
 rtl/scene_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/scene_sequencer.sv
// ---------------------------------------------------------------------------
// scene_sequencer
//
// Top-level render controller. It runs the vertex loader once, optionally
// clears the frame buffer, and then hands each triangle of the scene in turn
// to the filled-triangle rasteriser. When the scene is complete it releases
// the VGA timing block. In continuous mode it re-clears and re-draws the
// scene on every frame tick without rerunning the loader.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   start        begin a pass (sampled in IDLE); in DISPLAY returns to IDLE
//   continuous   redraw on each frame_tick while displaying
//   tri_count    triangles to draw, clamped to MAX_TRIS, sampled on start
//   frame_tick   one-cycle pulse at the start of vertical blank
//   loader_*     vertex loader reset pulse / start level / done input
//   ram_addr     base word address of the current triangle
//   rast_*       rasteriser restart pulse, pixel stream and done input
//   pix_x/pix_y  VGA scan position, used as read address while displaying
//   fb_*         frame-buffer write enable, {x,y} address and pixel value
//   vga_reset    holds the VGA timing block in reset until a scene is ready
//   busy         high in every state except IDLE and DISPLAY
//   frame_done   one-cycle pulse on entry to DISPLAY
//   tri_index    index of the triangle being drawn
// ---------------------------------------------------------------------------
module scene_sequencer #(
   parameter int MAX_TRIS      = 8,
   parameter int WORDS_PER_TRI = 9,
   parameter int ADDR_W        = 8,
   parameter int CNT_W         = 4,
   parameter int X_W           = 10,
   parameter int Y_W           = 9,
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int CLEAR_EN      = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               continuous,
   input  logic [CNT_W-1:0]   tri_count,
   input  logic               frame_tick,
   output logic               loader_reset,
   output logic               loader_start,
   input  logic               loader_done,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               rast_reset,
   input  logic               rast_valid,
   input  logic               rast_done,
   input  logic [X_W-1:0]     rast_x,
   input  logic [Y_W-1:0]     rast_y,
   input  logic [X_W-1:0]     pix_x,
   input  logic [Y_W-1:0]     pix_y,
   output logic               fb_we,
   output logic [X_W+Y_W-1:0] fb_addr,
   output logic               fb_wdata,
   output logic               vga_reset,
   output logic               busy,
   output logic               frame_done,
   output logic [CNT_W-1:0]   tri_index
);

   localparam logic [CNT_W-1:0]  N_MAX     = CNT_W'(MAX_TRIS);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORDS_PER_TRI);
   localparam logic [X_W-1:0]    CX_LAST   = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]    CY_LAST   = Y_W'(V_ACTIVE - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LRST,
      S_LGO,
      S_LWAIT,
      S_CLEAR,
      S_DRAW_SETUP,
      S_TRST,
      S_TDRAW,
      S_TNEXT,
      S_DISPLAY
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   n_tris;
   logic [X_W-1:0]     cx;
   logic [Y_W-1:0]     cy;

   // Main sequencer. Every control output is set on the transition into the
   // state that owns it, so outputs line up exactly with the state register.
   // Pulse outputs default low each cycle and are raised only on entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         n_tris       <= '0;
         cx           <= '0;
         cy           <= '0;
         loader_reset <= 1'b0;
         loader_start <= 1'b0;
         rast_reset   <= 1'b0;
         vga_reset    <= 1'b1;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         ram_addr     <= '0;
         tri_index    <= '0;
      end else begin
         loader_reset <= 1'b0;
         rast_reset   <= 1'b0;
         frame_done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_tris       <= (tri_count > N_MAX) ? N_MAX : tri_count;
                  loader_reset <= 1'b1;
                  busy         <= 1'b1;
                  state        <= S_LRST;
               end
            end
            S_LRST: begin
               loader_start <= 1'b1;
               state        <= S_LGO;
            end
            S_LGO: begin
               state <= S_LWAIT;
            end
            S_LWAIT: begin
               if (loader_done) begin
                  cx    <= '0;
                  cy    <= '0;
                  state <= (CLEAR_EN != 0) ? S_CLEAR : S_DRAW_SETUP;
               end
            end
            S_CLEAR: begin
               // Raster-order sweep: x runs fastest, y advances on each wrap.
               if (cx == CX_LAST) begin
                  cx <= '0;
                  if (cy == CY_LAST) begin
                     state <= S_DRAW_SETUP;
                  end else begin
                     cy <= cy + 1'b1;
                  end
               end else begin
                  cx <= cx + 1'b1;
               end
            end
            S_DRAW_SETUP: begin
               tri_index <= '0;
               ram_addr  <= '0;
               if (n_tris == '0) begin
                  vga_reset  <= 1'b0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= S_DISPLAY;
               end else begin
                  rast_reset <= 1'b1;
                  state      <= S_TRST;
               end
            end
            S_TRST: begin
               state <= S_TDRAW;
            end
            S_TDRAW: begin
               if (rast_done) begin
                  state <= S_TNEXT;
               end
            end
            S_TNEXT: begin
               // Base address is accumulated rather than multiplied out.
               if (tri_index == n_tris - CNT_W'(1)) begin
                  vga_reset  <= 1'b0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= S_DISPLAY;
               end else begin
                  tri_index  <= tri_index + 1'b1;
                  ram_addr   <= ram_addr + ADDR_STEP;
                  rast_reset <= 1'b1;
                  state      <= S_TRST;
               end
            end
            S_DISPLAY: begin
               // A new start takes priority over a continuous redraw.
               if (start) begin
                  loader_start <= 1'b0;
                  vga_reset    <= 1'b1;
                  state        <= S_IDLE;
               end else if (continuous && frame_tick) begin
                  cx    <= '0;
                  cy    <= '0;
                  busy  <= 1'b1;
                  state <= (CLEAR_EN != 0) ? S_CLEAR : S_DRAW_SETUP;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Frame-buffer port mux. The write enable follows rast_valid in the same
   // cycle so that each pixel is written with the coordinates it arrived with,
   // including a pixel that arrives together with rast_done.
   always_comb begin
      fb_we    = 1'b0;
      fb_wdata = 1'b0;
      fb_addr  = '0;
      case (state)
         S_CLEAR: begin
            fb_we    = 1'b1;
            fb_wdata = 1'b0;
            fb_addr  = {cx, cy};
         end
         S_TDRAW: begin
            fb_we    = rast_valid;
            fb_wdata = 1'b1;
            fb_addr  = {rast_x, rast_y};
         end
         S_DISPLAY: begin
            fb_addr = {pix_x, pix_y};
         end
         default: begin
            fb_addr = '0;
         end
      endcase
   end

endmodule
